ula_op_sequencer: RTL and testbench
===================================

ULA_OP_SEQUENCER -- requirements
Module: ula_op_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, opcode/argument width.
REQ-002 Parameter ULA_WIDTH, default 24, ULA result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  opcode/arg pair offered.
REQ-006 instr_ready  output  1  sequencer can accept an instruction.
REQ-007 opcode  input  DATA_WIDTH  bytecode opcode.
REQ-008 arg  input  DATA_WIDTH  bytecode argument.
REQ-009 SEL_MUX1  output  2  operand-1 mux select to ULA block.
REQ-010 SEL_MUX2  output  2  operand-2 mux select (0 regArg, 1 tos, 2 pc).
REQ-011 CTRL_REG_OP1  output  1  operand-1 register load strobe.
REQ-012 CTRL_REG_OP2  output  1  operand-2 register load strobe.
REQ-013 SEL_ULA  output  4  ULA operation select.
REQ-014 ULA_OUT  input  ULA_WIDTH  ULA result.
REQ-015 REG_COMP_OUT  input  1  registered compare flag.
REQ-016 REG_OVERFLOW_OUT  input  1  registered overflow flag.
REQ-017 res_valid  output  1  result available.
REQ-018 res_ready  input  1  consumer accepts result.
REQ-019 res_data  output  ULA_WIDTH  captured ULA result.
REQ-020 res_comp, res_ovf  output  1 each  captured flags.
REQ-021 err_opcode  output  1  result belongs to an unsupported opcode/arg.

Function
REQ-022 States SHALL be IDLE, LOAD, EXEC, CAPT, RESP; encoding free.
REQ-023 instr_ready SHALL be 1 only in IDLE; accept = instr_valid & instr_ready at a rising edge.
REQ-024 On accept, decode SHALL register SEL_MUX1/SEL_MUX2/SEL_ULA; values held until next accept.
REQ-025 Decode: 0x17 ADD->SEL_ULA 0; 0x18 SUB->1; 0x14 MUL->2; 0x40 AND->3; 0x41 XOR->5; 0x42 OR->4; all with SEL_MUX1=0, SEL_MUX2=1.
REQ-026 0x6B COMPARE_OP with arg 0..5 SHALL give SEL_ULA=8+arg, SEL_MUX1=0, SEL_MUX2=1; arg>5 is unsupported.
REQ-027 0x6E JUMP_FORWARD SHALL give SEL_ULA=0, SEL_MUX1=1, SEL_MUX2=2.
REQ-028 Supported accept: IDLE->LOAD->EXEC->CAPT->RESP, one cycle each; accept at edge N gives res_valid=1 from edge N+4.
REQ-029 CTRL_REG_OP1 and CTRL_REG_OP2 SHALL both be 1 during LOAD only, 0 in all other states.
REQ-030 On entering RESP from CAPT, res_data<=ULA_OUT, res_comp<=REG_COMP_OUT, res_ovf<=REG_OVERFLOW_OUT, err_opcode<=0.
REQ-031 Unsupported accept: IDLE->RESP directly; no strobes; SEL_* keep previous values; res_data=0, res_comp=0, res_ovf=0, err_opcode=1.
REQ-032 RESP: res_valid=1 and res_* stable until res_ready=1 at an edge, then ->IDLE; res_valid=0 otherwise.
REQ-033 res_ready in the same cycle res_valid rises SHALL complete the transfer at that edge; no result dropped or duplicated.
REQ-034 instr_valid while not in IDLE SHALL be ignored (no state change); opcode/arg need not be held after accept.
REQ-035 Minimum throughput: one supported instruction per 5 cycles; one unsupported per 2 cycles.

Reset
REQ-036 reset=0 SHALL immediately force IDLE, instr_ready=1, res_valid=0, strobes=0, SEL_MUX1=SEL_MUX2=0, SEL_ULA=0, res_data=0, res_comp=res_ovf=err_opcode=0.
REQ-037 reset asserted mid-sequence SHALL abandon the operation; no res_valid after release until a new accept.
REQ-038 After reset release, first accept possible at the first rising edge with reset=1.

Verification
REQ-039 Reset, then ADD (0x17,arg 0), ULA_OUT=0x000123, res_ready=1 -> strobes high exactly edge N+1 cycle, res_valid at N+4, res_data=0x000123, err_opcode=0.
REQ-040 COMPARE_OP arg=2, REG_COMP_OUT=1 -> SEL_ULA=10, SEL_MUX2=1, res_comp=1; arg=7 -> err_opcode=1, res_valid at N+1, no strobes.
REQ-041 JUMP_FORWARD arg=0x10 -> SEL_MUX1=1, SEL_MUX2=2, SEL_ULA=0; REG_OVERFLOW_OUT=1 -> res_ovf=1.
REQ-042 res_ready=0 for 6 cycles in RESP while ULA_OUT changes -> res_valid/res_data stable, instr_ready=0, extra instr_valid ignored.
REQ-043 Opcode 0xFF -> err_opcode=1, res_data=0; reset=0 asserted during EXEC of MUL -> immediate IDLE values per REQ-036, no result after release.

Source files
------------

// File: rtl/ula_op_sequencer.sv
// Bytecode-to-ULA control sequencer: decodes one opcode/arg pair, steps the ULA
// datapath through load/execute/capture and holds the result until it is consumed.
module ula_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ULA_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0] arg,
    output logic [1:0]            SEL_MUX1,
    output logic [1:0]            SEL_MUX2,
    output logic                  CTRL_REG_OP1,
    output logic                  CTRL_REG_OP2,
    output logic [3:0]            SEL_ULA,
    input  logic [ULA_WIDTH-1:0]  ULA_OUT,
    input  logic                  REG_COMP_OUT,
    input  logic                  REG_OVERFLOW_OUT,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ULA_WIDTH-1:0]  res_data,
    output logic                  res_comp,
    output logic                  res_ovf,
    output logic                  err_opcode
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        CAPT,
        RESP
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OP_ADD  = DATA_WIDTH'(8'h17);
    localparam logic [DATA_WIDTH-1:0] OP_SUB  = DATA_WIDTH'(8'h18);
    localparam logic [DATA_WIDTH-1:0] OP_MUL  = DATA_WIDTH'(8'h14);
    localparam logic [DATA_WIDTH-1:0] OP_AND  = DATA_WIDTH'(8'h40);
    localparam logic [DATA_WIDTH-1:0] OP_XOR  = DATA_WIDTH'(8'h41);
    localparam logic [DATA_WIDTH-1:0] OP_OR   = DATA_WIDTH'(8'h42);
    localparam logic [DATA_WIDTH-1:0] OP_CMP  = DATA_WIDTH'(8'h6B);
    localparam logic [DATA_WIDTH-1:0] OP_JMPF = DATA_WIDTH'(8'h6E);

    state_t               r_state;
    state_t               w_stateNext;
    logic                 w_accept;
    logic                 w_supported;
    logic [1:0]           w_selMux1;
    logic [1:0]           w_selMux2;
    logic [3:0]           w_selUla;
    logic [1:0]           r_selMux1;
    logic [1:0]           r_selMux2;
    logic [3:0]           r_selUla;
    logic [ULA_WIDTH-1:0] r_resData;
    logic                 r_resComp;
    logic                 r_resOvf;
    logic                 r_errOpcode;

    assign w_accept = instr_valid && (r_state == IDLE);

    // Compare ops map arg 0..5 onto ULA selects 8..13; anything larger is rejected.
    always_comb begin
        w_supported = 1'b1;
        w_selMux1   = 2'd0;
        w_selMux2   = 2'd1;
        w_selUla    = 4'd0;
        case (opcode)
            OP_ADD:  w_selUla = 4'd0;
            OP_SUB:  w_selUla = 4'd1;
            OP_MUL:  w_selUla = 4'd2;
            OP_AND:  w_selUla = 4'd3;
            OP_XOR:  w_selUla = 4'd5;
            OP_OR:   w_selUla = 4'd4;
            OP_CMP: begin
                w_supported = (arg <= DATA_WIDTH'(5));
                w_selUla    = 4'd8 + {1'b0, arg[2:0]};
            end
            OP_JMPF: begin
                w_selMux1 = 2'd1;
                w_selMux2 = 2'd2;
            end
            default: w_supported = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_stateNext = w_supported ? LOAD : RESP;
            LOAD:    w_stateNext = EXEC;
            EXEC:    w_stateNext = CAPT;
            CAPT:    w_stateNext = RESP;
            RESP:    if (res_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Selects change only on a supported accept so a rejected opcode leaves the datapath alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_selMux1   <= 2'd0;
            r_selMux2   <= 2'd0;
            r_selUla    <= 4'd0;
            r_resData   <= '0;
            r_resComp   <= 1'b0;
            r_resOvf    <= 1'b0;
            r_errOpcode <= 1'b0;
        end else begin
            if (w_accept && w_supported) begin
                r_selMux1 <= w_selMux1;
                r_selMux2 <= w_selMux2;
                r_selUla  <= w_selUla;
            end
            if (w_accept && !w_supported) begin
                r_resData   <= '0;
                r_resComp   <= 1'b0;
                r_resOvf    <= 1'b0;
                r_errOpcode <= 1'b1;
            end
            if (r_state == CAPT) begin
                r_resData   <= ULA_OUT;
                r_resComp   <= REG_COMP_OUT;
                r_resOvf    <= REG_OVERFLOW_OUT;
                r_errOpcode <= 1'b0;
            end
        end
    end

    assign instr_ready  = (r_state == IDLE);
    assign CTRL_REG_OP1 = (r_state == LOAD);
    assign CTRL_REG_OP2 = (r_state == LOAD);
    assign res_valid    = (r_state == RESP);
    assign SEL_MUX1     = r_selMux1;
    assign SEL_MUX2     = r_selMux2;
    assign SEL_ULA      = r_selUla;
    assign res_data     = r_resData;
    assign res_comp     = r_resComp;
    assign res_ovf      = r_resOvf;
    assign err_opcode   = r_errOpcode;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Self-checking bench for ula_op_sequencer: directed scenarios plus random
// instruction streams compared against a transaction-level reference model.
module tb_ula_op_sequencer;

    logic        clk;
    logic        reset;
    logic        instrValid;
    logic        instrReady;
    logic [7:0]  opcode;
    logic [7:0]  arg;
    logic [1:0]  selMux1;
    logic [1:0]  selMux2;
    logic        ctrlOp1;
    logic        ctrlOp2;
    logic [3:0]  selUla;
    logic [23:0] ulaOut;
    logic        compOut;
    logic        ovfOut;
    logic        resValid;
    logic        resReady;
    logic [23:0] resData;
    logic        resComp;
    logic        resOvf;
    logic        errOpcode;

    int total = 0;
    int bad   = 0;

    logic [1:0] expMux1 = 2'd0;
    logic [1:0] expMux2 = 2'd0;
    logic [3:0] expUla  = 4'd0;

    ula_op_sequencer #(.DATA_WIDTH(8), .ULA_WIDTH(24)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instrValid),
        .instr_ready      (instrReady),
        .opcode           (opcode),
        .arg              (arg),
        .SEL_MUX1         (selMux1),
        .SEL_MUX2         (selMux2),
        .CTRL_REG_OP1     (ctrlOp1),
        .CTRL_REG_OP2     (ctrlOp2),
        .SEL_ULA          (selUla),
        .ULA_OUT          (ulaOut),
        .REG_COMP_OUT     (compOut),
        .REG_OVERFLOW_OUT (ovfOut),
        .res_valid        (resValid),
        .res_ready        (resReady),
        .res_data         (resData),
        .res_comp         (resComp),
        .res_ovf          (resOvf),
        .err_opcode       (errOpcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Opcode table as a lookup: returns whether the pair is legal and its selects.
    function automatic void refDecode(input logic [7:0] op, input logic [7:0] a, output bit ok,
                                      output logic [1:0] m1, output logic [1:0] m2, output logic [3:0] u);
        ok = 1; m1 = 2'd0; m2 = 2'd1; u = 4'd0;
        if      (op == 8'h17) u = 4'd0;
        else if (op == 8'h18) u = 4'd1;
        else if (op == 8'h14) u = 4'd2;
        else if (op == 8'h40) u = 4'd3;
        else if (op == 8'h42) u = 4'd4;
        else if (op == 8'h41) u = 4'd5;
        else if (op == 8'h6B) begin
            ok = (a < 8'd6);
            u  = 4'(8 + int'(a) % 16);
        end else if (op == 8'h6E) begin
            m1 = 2'd1; m2 = 2'd2;
        end else ok = 0;
    endfunction

    task automatic checkSels(input string tag);
        checkOutput({tag, "_selMux1"}, 32'(selMux1), 32'(expMux1));
        checkOutput({tag, "_selMux2"}, 32'(selMux2), 32'(expMux2));
        checkOutput({tag, "_selUla"},  32'(selUla),  32'(expUla));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_instrReady"}, 32'(instrReady), 32'd1);
        checkOutput({tag, "_resValid"},   32'(resValid),   32'd0);
        checkOutput({tag, "_strobes"},    32'({ctrlOp1, ctrlOp2}), 32'd0);
    endtask

    // Entered just after a negedge with the DUT idle; returns just after a negedge, idle again.
    task automatic applyStimulus(input logic [7:0] op, input logic [7:0] a, input int hold,
                                 input bit fixed, input logic [23:0] fixUla, input bit fixComp, input bit fixOvf);
        bit          ok;
        logic [1:0]  m1, m2;
        logic [3:0]  u;
        logic [23:0] expData;
        bit          expComp, expOvf, expErr;
        refDecode(op, a, ok, m1, m2, u);
        checkIdle("pre_accept");
        instrValid = 1'b1; opcode = op; arg = a; resReady = 1'b0;
        @(posedge clk); #1;
        instrValid = 1'b0; opcode = 8'($urandom); arg = 8'($urandom);
        if (ok) begin
            expMux1 = m1; expMux2 = m2; expUla = u;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                checkOutput("busy_strobe1", 32'(ctrlOp1), 32'(k == 1));
                checkOutput("busy_strobe2", 32'(ctrlOp2), 32'(k == 1));
                checkOutput("busy_resValid", 32'(resValid), 32'd0);
                checkOutput("busy_instrReady", 32'(instrReady), 32'd0);
                checkSels("busy");
                ulaOut  = fixed ? fixUla  : 24'($urandom);
                compOut = fixed ? fixComp : 1'($urandom);
                ovfOut  = fixed ? fixOvf  : 1'($urandom);
                instrValid = 1'($urandom);
                opcode = 8'($urandom);
                if (k == 3) begin
                    expData = ulaOut; expComp = compOut; expOvf = ovfOut;
                    resReady = (hold == 0);
                end
            end
            expErr = 0;
        end else begin
            expData = '0; expComp = 0; expOvf = 0; expErr = 1;
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            checkOutput("resp_resValid", 32'(resValid), 32'd1);
            checkOutput("resp_instrReady", 32'(instrReady), 32'd0);
            checkOutput("resp_strobes", 32'({ctrlOp1, ctrlOp2}), 32'd0);
            checkOutput("resp_resData", 32'(resData), 32'(expData));
            checkOutput("resp_resComp", 32'(resComp), 32'(expComp));
            checkOutput("resp_resOvf", 32'(resOvf), 32'(expOvf));
            checkOutput("resp_errOpcode", 32'(errOpcode), 32'(expErr));
            checkSels("resp");
            ulaOut = 24'($urandom); compOut = 1'($urandom); ovfOut = 1'($urandom);
            instrValid = 1'($urandom); opcode = 8'($urandom);
            resReady = (h == hold);
        end
        @(negedge clk);
        instrValid = 1'b0;
        resReady = 1'($urandom);
        checkIdle("post_resp");
        checkSels("post_resp");
    endtask

    task automatic applyReset(input int lowCycles);
        reset = 1'b0;
        #1;
        expMux1 = 2'd0; expMux2 = 2'd0; expUla = 4'd0;
        checkIdle("reset");
        checkSels("reset");
        checkOutput("reset_resData", 32'(resData), 32'd0);
        checkOutput("reset_flags", 32'({resComp, resOvf, errOpcode}), 32'd0);
        repeat (lowCycles) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] pool [8];
        logic [7:0] op, a;
        pool = '{8'h17, 8'h18, 8'h14, 8'h40, 8'h41, 8'h42, 8'h6B, 8'h6E};
        reset = 1'b0; instrValid = 1'b0; resReady = 1'b0;
        opcode = 8'h00; arg = 8'h00; ulaOut = '0; compOut = 1'b0; ovfOut = 1'b0;
        @(negedge clk);
        applyReset(2);

        applyStimulus(8'h17, 8'h00, 0, 1, 24'h000123, 0, 0);
        applyStimulus(8'h6B, 8'h02, 1, 1, 24'h000001, 1, 0);
        applyStimulus(8'h6B, 8'h07, 0, 0, '0, 0, 0);
        applyStimulus(8'h6E, 8'h10, 2, 1, 24'h000010, 0, 1);
        applyStimulus(8'h14, 8'h05, 6, 0, '0, 0, 0);
        applyStimulus(8'hFF, 8'h00, 3, 0, '0, 0, 0);
        applyStimulus(8'h6B, 8'h05, 0, 0, '0, 0, 0);
        applyStimulus(8'h6B, 8'h06, 0, 0, '0, 0, 0);

        // Abort a MUL while it is executing, then confirm nothing is delivered afterwards.
        checkIdle("mul_pre");
        instrValid = 1'b1; opcode = 8'h14; arg = 8'h03;
        @(posedge clk); #1;
        instrValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mul_exec_instrReady", 32'(instrReady), 32'd0);
        applyReset(1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkIdle("after_abort");
        end
        applyStimulus(8'h40, 8'h00, 0, 0, '0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
            a  = (op == 8'h6B) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            applyStimulus(op, a, $urandom_range(0, 3), 0, '0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
